ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  Front end of the keyboard path. Takes the raw PS2_CLK/PS2_DAT pins and deserializes 11-bit PS/2 frames
//  (start, 8 data bits LSB first, parity, stop). It resolves E0/F0 prefixes into single key events with
//  make/break and extended flags. Downstream, the keycode RAM writer and the HEX display logic consume
//  key_code/key_valid.
// PARAMETERS
//  FILTER_LEN      4     consecutive equal synced PS2_CLK samples needed to accept a level change
//  TIMEOUT_CYCLES  5000  idle CLK cycles between falling edges before a partial frame is aborted (100 us @ 50 MHz)
//  PARITY_ODD      1     1: (^data)^parity must be 1 (PS/2 standard); 0: must be 0
// PORTS
//  CLK        in   1  system clock
//  RST        in   1  synchronous, active-high reset
//  PS2_CLK    in   1  raw keyboard clock, asynchronous to CLK
//  PS2_DAT    in   1  raw keyboard data, asynchronous to CLK
//  byte_out   out  8  last correctly framed byte, including prefixes
//  byte_valid out  1  1-cycle pulse: byte_out updated
//  key_code   out  8  scancode of the completed key event (prefix bytes stripped)
//  key_ext    out  1  event was preceded by E0
//  key_break  out  1  event was preceded by F0 (key release)
//  key_valid  out  1  1-cycle pulse: key_code/key_ext/key_break valid
//  frame_err  out  1  1-cycle pulse: parity, stop or timeout error
// BEHAVIOUR
//  Reset: all outputs 0; synchronizers and filtered clock = 1; frame and prefix FSMs in IDLE; counters 0.
//  Synchronizer: 2-FF on PS2_CLK and PS2_DAT.
//  Filter: clk_f toggles only after FILTER_LEN consecutive synced samples differ from it.
//  Strobe: 1-cycle pulse on the 1->0 transition of clk_f. Data is sampled from synced PS2_DAT in that cycle.
//  Frame FSM (transitions only on strobe, except timeout):
//   IDLE:   dat=0 -> DATA, bit_cnt=0; dat=1 -> stay, no error.
//   DATA:   shift = {dat, shift[7:1]}; after the 8th bit -> PARITY.
//   PARITY: latch parity_ok per PARITY_ODD -> STOP.
//   STOP:   dat=1 && parity_ok -> byte_valid, byte_out=shift; otherwise frame_err. Either way -> IDLE.
//  Timeout: counter clears on each strobe and in IDLE. When it reaches TIMEOUT_CYCLES-1 outside IDLE:
//   go to IDLE and pulse frame_err. A strobe in the same cycle wins and clears the counter.
//  Prefix FSM (advances on byte_valid): P_IDLE, P_EXT, P_BRK, P_EXT_BRK.
//   E0 -> set ext; F0 -> set brk.
//   Any other byte -> key_code=byte, key_ext=ext, key_break=brk, key_valid pulse, back to P_IDLE.
//   In P_IDLE only, AA/FA/EE/FE/FC are dropped: no key_valid, no state change.
//   Repeated E0 or F0 is idempotent.
//   frame_err forces P_IDLE, discarding pending prefixes.
//  Latency: STOP strobe in cycle N -> byte_valid in N+1 -> key_valid in N+2.
//  key_code/key_ext/key_break hold their value until the next key_valid.
//  byte_out holds until the next byte_valid.
//  Reset mid-frame or mid-prefix: immediate return to reset state; no pulses in the reset cycle or the one after.
// STRUCTURE
//  ps2_pkg:       frame_state_t, prefix_state_t enums;
//                 PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_BAT=8'hAA, PS2_ACK=8'hFA, PS2_ECHO=8'hEE,
//                 PS2_RESEND=8'hFE, PS2_BAT_ERR=8'hFC.
//  ps2_frame_rx:  sub-module with sync, filter, strobe, frame FSM and timeout; outputs byte_out/byte_valid/frame_err.
//  ps2_key_decoder: instantiates ps2_frame_rx and adds the prefix FSM.
// TESTING  (bench drives PS2 half-period >= FILTER_LEN+3 CLK cycles, odd parity unless stated)
//  1C                    -> byte_valid byte_out=1C; key_valid key_code=1C ext=0 break=0, exactly 2 cycles after stop strobe.
//  F0,1C                 -> one key_valid only: key_code=1C break=1 ext=0; byte_valid pulses twice.
//  E0,F0,75              -> single key_valid key_code=75 ext=1 break=1; E0,75 -> ext=1 break=0.
//  1C with flipped parity, or stop=0 -> frame_err pulse, no byte_valid/key_valid; next good 1C decodes normally.
//  Start + 4 bits, then silence -> frame_err exactly TIMEOUT_CYCLES after last strobe; then F0 pending + timeout
//                                  -> next 1C reports break=0.
//  AA after power-up -> byte_valid only, no key_valid.
//  RST asserted mid-DATA -> outputs 0; following full 1C frame decodes correctly.
//  1-cycle glitch on PS2_CLK -> no strobe.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and scancode constants for the PS/2 keyboard receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    F_IDLE,
    F_DATA,
    F_PARITY,
    F_STOP
  } frame_state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_EXT,
    P_BRK,
    P_EXT_BRK
  } prefix_state_t;

  localparam logic [7:0] PS2_EXT     = 8'hE0;
  localparam logic [7:0] PS2_BRK     = 8'hF0;
  localparam logic [7:0] PS2_BAT     = 8'hAA;
  localparam logic [7:0] PS2_ACK     = 8'hFA;
  localparam logic [7:0] PS2_ECHO    = 8'hEE;
  localparam logic [7:0] PS2_RESEND  = 8'hFE;
  localparam logic [7:0] PS2_BAT_ERR = 8'hFC;

  // Keyboard status/handshake bytes that never represent a key on their own.
  function automatic logic is_status_byte(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_BAT_ERR);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, clock glitch filter, falling-edge
// strobe, 11-bit frame deserializer and inter-bit timeout.
module ps2_frame_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int PARITY_ODD     = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);
  import ps2_pkg::*;

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TCW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
  // Firing one count early lets the registered frame_err land exactly
  // TIMEOUT_CYCLES cycles after the last strobe, as the count reaches TIMEOUT_CYCLES-1.
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYCLES - 2);

  logic [1:0] pin_raw;
  logic [1:0] pin_sync;
  logic       clk_s;
  logic       dat_s;

  assign pin_raw = {PS2_DAT, PS2_CLK};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      // Two-flop synchronizer per pin; idle-high lines reset to 1.
      always_ff @(posedge CLK) begin
        if (RST) begin
          s1_reg <= 1'b1;
          s2_reg <= 1'b1;
        end else begin
          s1_reg <= pin_raw[gi];
          s2_reg <= s1_reg;
        end
      end
      assign pin_sync[gi] = s2_reg;
    end
  endgenerate

  assign clk_s = pin_sync[0];
  assign dat_s = pin_sync[1];

  logic           clk_f_reg;
  logic           clk_f_d_reg;
  logic [FCW-1:0] filt_cnt_reg;
  logic           strobe;

  // Glitch filter: follow the synced clock only after FILTER_LEN differing samples.
  always_ff @(posedge CLK) begin
    if (RST) begin
      clk_f_reg    <= 1'b1;
      clk_f_d_reg  <= 1'b1;
      filt_cnt_reg <= '0;
    end else begin
      clk_f_d_reg <= clk_f_reg;
      if (clk_s == clk_f_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FILT_LAST) begin
        filt_cnt_reg <= '0;
        clk_f_reg    <= clk_s;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  assign strobe = clk_f_d_reg & ~clk_f_reg;

  frame_state_t   state_reg, state_next;
  logic [2:0]     bit_cnt_reg, bit_cnt_next;
  logic [7:0]     shift_reg, shift_next;
  logic           parity_ok_reg, parity_ok_next;
  logic [TCW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [7:0]     byte_out_reg, byte_out_next;
  logic           byte_valid_reg, byte_valid_next;
  logic           frame_err_reg, frame_err_next;

  // Frame FSM and timeout state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= F_IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      parity_ok_reg  <= 1'b0;
      tmo_cnt_reg    <= '0;
      byte_out_reg   <= '0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      parity_ok_reg  <= parity_ok_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      byte_out_reg   <= byte_out_next;
      byte_valid_reg <= byte_valid_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  // Frame FSM: advances on strobes; a strobe pre-empts a coincident timeout.
  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    parity_ok_next  = parity_ok_reg;
    byte_out_next   = byte_out_reg;
    byte_valid_next = 1'b0;
    frame_err_next  = 1'b0;
    tmo_cnt_next    = tmo_cnt_reg + 1'b1;
    if (strobe || state_reg == F_IDLE) begin
      tmo_cnt_next = '0;
    end
    if (strobe) begin
      case (state_reg)
        F_IDLE: begin
          if (!dat_s) begin
            state_next   = F_DATA;
            bit_cnt_next = '0;
          end
        end
        F_DATA: begin
          shift_next = {dat_s, shift_reg[7:1]};
          if (bit_cnt_reg == 3'd7) begin
            state_next = F_PARITY;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
        F_PARITY: begin
          parity_ok_next = (((^shift_reg) ^ dat_s) == (PARITY_ODD != 0));
          state_next     = F_STOP;
        end
        default: begin
          if (dat_s && parity_ok_reg) begin
            byte_valid_next = 1'b1;
            byte_out_next   = shift_reg;
          end else begin
            frame_err_next = 1'b1;
          end
          state_next = F_IDLE;
        end
      endcase
    end else if (state_reg != F_IDLE && tmo_cnt_reg == TMO_LAST) begin
      state_next     = F_IDLE;
      frame_err_next = 1'b1;
    end
  end

  assign byte_out   = byte_out_reg;
  assign byte_valid = byte_valid_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: frame receiver plus E0/F0 prefix resolution into key events.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int PARITY_ODD     = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic       frame_err
);
  import ps2_pkg::*;

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .PARITY_ODD    (PARITY_ODD)
  ) u_frame_rx (
    .CLK       (CLK),
    .RST       (RST),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .byte_out  (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (rx_err)
  );

  prefix_state_t p_state_reg, p_state_next;
  logic [7:0]    key_code_reg, key_code_next;
  logic          key_ext_reg, key_ext_next;
  logic          key_break_reg, key_break_next;
  logic          key_valid_reg, key_valid_next;
  logic          pend_ext;
  logic          pend_brk;

  assign pend_ext = (p_state_reg == P_EXT) || (p_state_reg == P_EXT_BRK);
  assign pend_brk = (p_state_reg == P_BRK) || (p_state_reg == P_EXT_BRK);

  // Prefix FSM and key event output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      p_state_reg   <= P_IDLE;
      key_code_reg  <= '0;
      key_ext_reg   <= 1'b0;
      key_break_reg <= 1'b0;
      key_valid_reg <= 1'b0;
    end else begin
      p_state_reg   <= p_state_next;
      key_code_reg  <= key_code_next;
      key_ext_reg   <= key_ext_next;
      key_break_reg <= key_break_next;
      key_valid_reg <= key_valid_next;
    end
  end

  // Accumulate E0/F0 prefixes; the first other byte completes the key event.
  always_comb begin
    p_state_next   = p_state_reg;
    key_code_next  = key_code_reg;
    key_ext_next   = key_ext_reg;
    key_break_next = key_break_reg;
    key_valid_next = 1'b0;
    if (rx_err) begin
      p_state_next = P_IDLE;
    end else if (rx_valid) begin
      if (rx_byte == PS2_EXT) begin
        p_state_next = pend_brk ? P_EXT_BRK : P_EXT;
      end else if (rx_byte == PS2_BRK) begin
        p_state_next = pend_ext ? P_EXT_BRK : P_BRK;
      end else if (p_state_reg == P_IDLE && is_status_byte(rx_byte)) begin
        p_state_next = P_IDLE;
      end else begin
        key_code_next  = rx_byte;
        key_ext_next   = pend_ext;
        key_break_next = pend_brk;
        key_valid_next = 1'b1;
        p_state_next   = P_IDLE;
      end
    end
  end

  assign byte_out   = rx_byte;
  assign byte_valid = rx_valid;
  assign frame_err  = rx_err;
  assign key_code   = key_code_reg;
  assign key_ext    = key_ext_reg;
  assign key_break  = key_break_reg;
  assign key_valid  = key_valid_reg;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios then random byte streams,
// checked against an event-level model of the keyboard protocol.
module tb_ps2_key_decoder;

  localparam int F = 4;    // filter length
  localparam int T = 200;  // timeout cycles
  localparam int H = 10;   // PS/2 half period in CLK cycles

  localparam logic [1:0] K_BYTE = 2'd0;
  localparam logic [1:0] K_KEY  = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  data;
    logic        ext;
    logic        brk;
    logic [31:0] cyc;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic       frame_err;

  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          txn = 0;

  ev_t exp_q[$];
  ev_t act_q[$];

  // model state
  logic [7:0] m_byte, m_key;
  logic       m_kext, m_kbrk, m_pext, m_pbrk;

  ps2_key_decoder #(
    .FILTER_LEN    (F),
    .TIMEOUT_CYCLES(T),
    .PARITY_ODD    (1)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .PS2_CLK   (ps2_clk),
    .PS2_DAT   (ps2_dat),
    .byte_out  (byte_out),
    .byte_valid(byte_valid),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_break (key_break),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk_ev(input logic [1:0] kind, input logic [7:0] data,
                                input logic ext, input logic brk, input int unsigned c);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.ext  = ext;
    e.brk  = brk;
    e.cyc  = c;
    return e;
  endfunction

  // Record every output pulse with its cycle stamp.
  always @(negedge clk) begin
    if (byte_valid) act_q.push_back(mk_ev(K_BYTE, byte_out, 1'b0, 1'b0, cyc));
    if (key_valid)  act_q.push_back(mk_ev(K_KEY, key_code, key_ext, key_break, cyc));
    if (frame_err)  act_q.push_back(mk_ev(K_ERR, 8'h00, 1'b0, 1'b0, cyc));
  end

  task automatic model_reset();
    m_byte = 8'h00; m_key = 8'h00; m_kext = 1'b0; m_kbrk = 1'b0;
    m_pext = 1'b0;  m_pbrk = 1'b0;
  endtask

  // Drive nbits of a frame; returns the cycle stamp of the last falling edge.
  task automatic drive_bits(input logic [10:0] bits, input int nbits, output int unsigned last_fall);
    last_fall = 0;
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      last_fall = cyc;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic check_events(input string tag);
    ev_t e, a;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : '1;
      vectors++;
      assert (a === e) else begin
        miscompares++;
        $error("FAIL %s event: observed kind=%0d data=%h ext=%b brk=%b cyc=%0d, expected kind=%0d data=%h ext=%b brk=%b cyc=%0d",
               tag, a.kind, a.data, a.ext, a.brk, a.cyc, e.kind, e.data, e.ext, e.brk, e.cyc);
      end
    end
    vectors++;
    assert (act_q.size() == 0) else begin
      miscompares++;
      a = act_q[0];
      $error("FAIL %s extra events: observed %0d (first kind=%0d data=%h cyc=%0d), expected 0",
             tag, act_q.size(), a.kind, a.data, a.cyc);
      act_q.delete();
    end
    vectors++;
    assert ({byte_out, key_code, key_ext, key_break} === {m_byte, m_key, m_kext, m_kbrk}) else begin
      miscompares++;
      $error("FAIL %s held outputs: observed byte=%h key=%h ext=%b brk=%b, expected byte=%h key=%h ext=%b brk=%b",
             tag, byte_out, key_code, key_ext, key_break, m_byte, m_key, m_kext, m_kbrk);
    end
  endtask

  // Send one frame (possibly corrupted or truncated) and predict its events.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0]  bits;
    int unsigned  lf;
    bits[0]   = 1'b0;
    bits[8:1] = b;
    bits[9]   = ~(^b) ^ bad_par;
    bits[10]  = ~bad_stop;
    txn++;
    $display("txn %0d: byte=%h nbits=%0d bad_par=%0d bad_stop=%0d", txn, b, nbits, bad_par, bad_stop);
    drive_bits(bits, nbits, lf);
    if (nbits < 11) begin
      exp_q.push_back(mk_ev(K_ERR, 8'h00, 1'b0, 1'b0, lf + F + 2 + T));
      m_pext = 1'b0; m_pbrk = 1'b0;
      repeat (T + F + 10) @(negedge clk);
    end else if (bad_par || bad_stop) begin
      exp_q.push_back(mk_ev(K_ERR, 8'h00, 1'b0, 1'b0, lf + F + 3));
      m_pext = 1'b0; m_pbrk = 1'b0;
    end else begin
      exp_q.push_back(mk_ev(K_BYTE, b, 1'b0, 1'b0, lf + F + 3));
      m_byte = b;
      if (b == 8'hE0) begin
        m_pext = 1'b1;
      end else if (b == 8'hF0) begin
        m_pbrk = 1'b1;
      end else if (!m_pext && !m_pbrk && (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC})) begin
        // status byte with no pending prefix: not a key
      end else begin
        exp_q.push_back(mk_ev(K_KEY, b, m_pext, m_pbrk, lf + F + 4));
        m_key = b; m_kext = m_pext; m_kbrk = m_pbrk;
        m_pext = 1'b0; m_pbrk = 1'b0;
      end
    end
    repeat (2 * H) @(negedge clk);
    check_events($sformatf("txn%0d", txn));
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  task automatic check_zero(input string tag);
    vectors++;
    assert ({byte_out, byte_valid, key_code, key_ext, key_break, key_valid, frame_err} === 21'd0) else begin
      miscompares++;
      $error("FAIL %s reset outputs: observed byte=%h bv=%b key=%h ext=%b brk=%b kv=%b err=%b, expected all 0",
             tag, byte_out, byte_valid, key_code, key_ext, key_break, key_valid, frame_err);
    end
  endtask

  logic [7:0]  pool [10];
  int unsigned lf_dummy;
  int          r;
  logic [7:0]  rb;

  initial begin
    pool = '{8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h1C, 8'h75, 8'h00};
    rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("power_on");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // status byte after power-up, then basic keys and prefixes
    send_good(8'hAA);
    send_good(8'h1C);
    send_good(8'hF0); send_good(8'h1C);
    send_good(8'hE0); send_good(8'hF0); send_good(8'h75);
    send_good(8'hE0); send_good(8'h75);
    send_good(8'hF0); send_good(8'hF0); send_good(8'h1C);

    // parity and stop errors, then recovery
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    send_good(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    send_good(8'h1C);

    // timeout, and a pending F0 discarded by a timeout
    send_frame(8'h1C, 1'b0, 1'b0, 5);
    send_good(8'hF0);
    send_frame(8'h5A, 1'b0, 1'b0, 5);
    send_good(8'h1C);

    // reset in the middle of a frame with an F0 pending
    send_good(8'hF0);
    txn++;
    $display("txn %0d: reset mid-frame", txn);
    drive_bits(11'b000_0001_1100_0 , 4, lf_dummy);
    rst = 1'b1;
    @(negedge clk);
    check_zero("mid_reset");
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_zero("post_reset");
    repeat (T + F + 10) @(negedge clk);
    check_events("reset_idle");
    send_good(8'h1C);

    // short low glitches on PS2_CLK with data low must not start a frame
    for (int g = 1; g <= 3; g += 2) begin
      txn++;
      $display("txn %0d: glitch of %0d cycles", txn, g);
      ps2_dat = 1'b0;
      ps2_clk = 1'b0;
      repeat (g) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (T + F + 20) @(negedge clk);
      ps2_dat = 1'b1;
      repeat (H) @(negedge clk);
      check_events($sformatf("glitch%0d", g));
    end
    send_good(8'h75);

    // random byte stream with occasional corruption and truncation
    for (int i = 0; i < 40; i++) begin
      rb = pool[$urandom_range(0, 9)];
      if (rb == 8'h00) rb = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 99);
      if (r < 8)       send_frame(rb, 1'b1, 1'b0, 11);
      else if (r < 14) send_frame(rb, 1'b0, 1'b1, 11);
      else if (r < 18) send_frame(rb, 1'b0, 1'b0, $urandom_range(1, 10));
      else             send_good(rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
